hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central hazard and pipeline-control unit for the 5-stage CPU: produces the stall, flush and forwarding-select signals that the IF/ID, ID/EX and EX/MEM pipeline registers and the EX operand muxes consume. It detects load-use hazards and EX-stage redirects, and runs a halt-drain state machine that retires older instructions before freezing the pipeline. It sits beside the datapath and reads the register-address and control fields already carried by the pipeline registers.

## Interface
Parameters:
- DRAIN_CYCLES, 3, number of bubble cycles spent in DRAIN before HALTED; minimum 1, width-safe up to 15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- id_rs1, id_rs2  in  5  source register addresses of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- id_halt  in  1  halt instruction decoded in ID
- ex_rs1, ex_rs2  in  5  source addresses held in ID/EX
- ex_rd  in  5; ex_RegWrite, ex_MemRead  in  1  destination and control of EX instruction
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_rd  in  5; mem_RegWrite  in  1  EX/MEM destination and write enable
- wb_rd  in  5; wb_RegWrite  in  1  MEM/WB destination and write enable
- pc_stall, ifid_stall  out  1  hold PC / IF/ID
- ifid_flush, idex_flush  out  1  bubble IF/ID / ID/EX
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- halted  out  1  pipeline frozen
- state  out  2  FSM state: 00 RUN, 01 DRAIN, 10 HALTED
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration)

## Operation
- Load-use (lu): ex_MemRead & ex_RegWrite & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Forwarding, per operand: 10 if mem_RegWrite & mem_rd≠0 & mem_rd==ex_rsX; otherwise 01 if wb_RegWrite & wb_rd≠0 & wb_rd==ex_rsX; otherwise 00. EX/MEM has priority. Forwarding is active in every state.
- RUN:
  - If ex_redirect: ifid_flush=1, idex_flush=1, pc_stall=ifid_stall=0. Redirect overrides both lu and id_halt, because the younger ID instruction is squashed.
  - Otherwise, if lu or id_halt: pc_stall=ifid_stall=idex_flush=1.
  - id_halt & !ex_redirect: next state DRAIN, drain counter loaded with DRAIN_CYCLES.
- DRAIN:
  - pc_stall=ifid_stall=idex_flush=1. ex_redirect and lu are ignored.
  - Counter decrements each cycle; when the counter equals 1, next state is HALTED.
- HALTED:
  - pc_stall=ifid_stall=idex_flush=1, halted=1.
  - Leaves HALTED only on reset.
- State 11 is illegal; it returns to RUN on the next edge and drives outputs as RUN.

## Timing
- Stall, flush and forwarding outputs are combinational from inputs and the current state, and are valid in the same cycle. The only registered elements are state, the drain counter and the perf counters.
- While rst=0:
  - All outputs are forced to 0 (fwd_a=fwd_b=00, state=00).
  - On the edge, state←RUN, counter←0, perf counters←0.
  - Reset mid-DRAIN or in HALTED returns to RUN after one edge.
- lu produces exactly one bubble: next cycle the ID/EX flush makes ex_MemRead=0, and the consumer receives the load via fwd 01.
- Redirect flush lasts one cycle per ex_redirect pulse.
- Halt timing: id_halt observed in cycle t (RUN).
  - Cycle t: stall and flush asserted.
  - Cycles t+1..t+DRAIN_CYCLES: state=01.
  - Cycle t+DRAIN_CYCLES+1 onward: state=10, halted=1.
- The halt instruction stays in IF/ID for the whole sequence.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments each cycle pc_stall=1 in RUN or DRAIN (not HALTED).
  - flush_cnt increments each cycle ex_redirect causes a flush in RUN.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- HAZARD_PERF_CNT_EN undefined: the ports remain and are tied to 0; no counter flops are built.

## Test plan
- Reset: hold rst=0 for 2 cycles with id_halt=1 and ex_redirect=1 → all outputs 0 and state=00. Release rst → state stays 00 until id_halt is sampled.
- Load-use: ex_MemRead=1, ex_RegWrite=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_stall=ifid_stall=idex_flush=1 for one cycle. Repeat with ex_rd=0 → all three stay 0.
- Forwarding: ex_rs1=7, mem_rd=7, mem_RegWrite=1, wb_rd=7, wb_RegWrite=1 → fwd_a=10. Then mem_RegWrite=0 → fwd_a=01. Then wb_rd=0 → fwd_a=00.
- Redirect with lu in the same cycle → ifid_flush=idex_flush=1 and pc_stall=ifid_stall=0.
- Halt with DRAIN_CYCLES=3: id_halt at cycle 10 → stall/flush in cycles 10–13, state=01 in cycles 11–13, halted=1 from cycle 14. ex_redirect=1 in cycle 12 is ignored. rst=0 in cycle 20 → state=00 at cycle 21.
- Perf (macro defined): one lu event, two redirect pulses, then halt with DRAIN_CYCLES=3 → stall_cnt=5 (1 + halt cycle + 3 drain), flush_cnt=2. Counters stay constant while HALTED.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bundle: datapath fields in, stall/flush/forward controls out.
// The master side is the datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_halt;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_redirect;
  logic [4:0]  mem_rd;
  logic        mem_RegWrite;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_halt, ex_rs1, ex_rs2, ex_rd,
    output ex_RegWrite, ex_MemRead, ex_redirect,
    output mem_rd, mem_RegWrite, wb_rd, wb_RegWrite,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush,
    input  fwd_a, fwd_b, halted, state,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_halt, ex_rs1, ex_rs2, ex_rd,
    input  ex_RegWrite, ex_MemRead, ex_redirect,
    input  mem_rd, mem_RegWrite, wb_rd, wb_RegWrite,
    output pc_stall, ifid_stall, ifid_flush, idex_flush,
    output fwd_a, fwd_b, halted, state,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / redirect hazard control, operand forwarding and halt-drain FSM.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_DRAIN = 2'b01,
    S_HALT  = 2'b10,
    S_ILL   = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;
  logic       stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halted;
  logic       redir_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs)
      sel = 2'b10;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == rs)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(bus.ex_rs1, bus.mem_RegWrite,
                    bus.mem_rd, bus.wb_RegWrite, bus.wb_rd);
    fwd_b = fwd_sel(bus.ex_rs2, bus.mem_RegWrite,
                    bus.mem_rd, bus.wb_RegWrite, bus.wb_rd);
  end

  assign lu = bus.ex_MemRead && bus.ex_RegWrite
           && bus.ex_rd != 5'd0
           && ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd)
            || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    redir_flush = 1'b0;
    unique case (state_q)
      S_DRAIN: begin
        stall      = 1'b1;
        idex_flush = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q <= 4'd1)
          state_d = S_HALT;
      end
      S_HALT: begin
        stall      = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        // Redirect squashes the ID instruction, so it beats lu and halt.
        if (bus.ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          redir_flush = 1'b1;
        end else if (lu || bus.id_halt) begin
          stall      = 1'b1;
          idex_flush = 1'b1;
        end
        if (state_q == S_ILL) begin
          state_d = S_RUN;
        end else if (bus.id_halt && !bus.ex_redirect) begin
          state_d = S_DRAIN;
          cnt_d   = 4'(DRAIN_CYCLES);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_stall   = rst & stall;
  assign bus.ifid_stall = rst & stall;
  assign bus.ifid_flush = rst & ifid_flush;
  assign bus.idex_flush = rst & idex_flush;
  assign bus.halted     = rst & halted;
  assign bus.fwd_a      = rst ? fwd_a : 2'b00;
  assign bus.fwd_b      = rst ? fwd_b : 2'b00;
  assign bus.state      = rst ? state_q : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && state_q != S_HALT
        && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (redir_flush && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = rst ? stall_cnt_q : 32'd0;
  assign bus.flush_cnt = rst ? flush_cnt_q : 32'd0;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences then
// randomized traffic against a cycle-indexed reference model.
module tb_hazard_ctrl;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  typedef struct packed {
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t e;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state: cycle index and the cycle halt was accepted.
  int          cyc = 0;
  int          halt_t = -1;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hif.mem_RegWrite && hif.mem_rd != 0 && hif.mem_rd == rs)
      return 2'b10;
    if (hif.wb_RegWrite && hif.wb_rd != 0 && hif.wb_rd == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_lu();
    logic hit1, hit2;
    hit1 = hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd;
    hit2 = hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd;
    return hif.ex_MemRead && hif.ex_RegWrite
        && hif.ex_rd != 0 && (hit1 || hit2);
  endfunction

  task automatic clr();
    rst = 1'b1;
    hif.id_rs1 = 0; hif.id_rs2 = 0;
    hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
    hif.id_halt = 0;
    hif.ex_rs1 = 0; hif.ex_rs2 = 0; hif.ex_rd = 0;
    hif.ex_RegWrite = 0; hif.ex_MemRead = 0;
    hif.ex_redirect = 0;
    hif.mem_rd = 0; hif.mem_RegWrite = 0;
    hif.wb_rd = 0; hif.wb_RegWrite = 0;
  endtask

  // Predict this cycle's outputs from the driven inputs, then advance.
  task automatic cycle();
    exp_t x;
    int   ph;
    x.cyc = cyc;
    x.e = '0;
    if (halt_t < 0) ph = 0;
    else if (cyc - halt_t <= D) ph = 1;
    else ph = 2;
    if (rst) begin
      x.e.fwd_a = ref_fwd(hif.ex_rs1);
      x.e.fwd_b = ref_fwd(hif.ex_rs2);
      x.e.state = 2'(ph);
      if (ph == 0) begin
        if (hif.ex_redirect) begin
          x.e.ifid_flush = 1;
          x.e.idex_flush = 1;
        end else if (ref_lu() || hif.id_halt) begin
          x.e.pc_stall = 1;
          x.e.ifid_stall = 1;
          x.e.idex_flush = 1;
        end
      end else begin
        x.e.pc_stall = 1;
        x.e.ifid_stall = 1;
        x.e.idex_flush = 1;
        x.e.halted = (ph == 2);
      end
`ifdef HAZARD_PERF_CNT_EN
      x.e.stall_cnt = m_stall;
      x.e.flush_cnt = m_flush;
`endif
      if (ph != 2 && x.e.pc_stall && m_stall != 32'hFFFF_FFFF)
        m_stall++;
      if (ph == 0 && hif.ex_redirect && m_flush != 32'hFFFF_FFFF)
        m_flush++;
      if (ph == 0 && hif.id_halt && !hif.ex_redirect)
        halt_t = cyc;
    end else begin
      halt_t = -1;
      m_stall = 0;
      m_flush = 0;
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      obs_t a;
      x = exp_q.pop_front();
      a.pc_stall   = hif.pc_stall;
      a.ifid_stall = hif.ifid_stall;
      a.ifid_flush = hif.ifid_flush;
      a.idex_flush = hif.idex_flush;
      a.fwd_a      = hif.fwd_a;
      a.fwd_b      = hif.fwd_b;
      a.halted     = hif.halted;
      a.state      = hif.state;
      a.stall_cnt  = hif.stall_cnt;
      a.flush_cnt  = hif.flush_cnt;
      n_total++;
      if (a === x.e) n_pass++;
      else
        $display("FAIL cycle%0d outputs got=%h want=%h",
                 x.cyc, a, x.e);
    end
  end

  initial begin
    clr();
    @(posedge clk);
    #1;
    // Reset with halt and redirect asserted
    rst = 0; hif.id_halt = 1; hif.ex_redirect = 1;
    run(2);
    clr();
    run(2);
    // Load-use, then the bubble cycle
    hif.ex_MemRead = 1; hif.ex_RegWrite = 1; hif.ex_rd = 5;
    hif.id_rs1 = 5; hif.id_use_rs1 = 1;
    cycle();
    hif.ex_MemRead = 0;
    cycle();
    hif.ex_MemRead = 1; hif.ex_rd = 0; hif.id_rs1 = 0;
    cycle();
    clr();
    // Forwarding priority
    hif.ex_rs1 = 7; hif.mem_rd = 7; hif.mem_RegWrite = 1;
    hif.wb_rd = 7; hif.wb_RegWrite = 1;
    cycle();
    hif.mem_RegWrite = 0;
    cycle();
    hif.wb_rd = 0;
    cycle();
    clr();
    // Redirect with lu and a second redirect pulse
    hif.ex_MemRead = 1; hif.ex_RegWrite = 1; hif.ex_rd = 9;
    hif.id_rs2 = 9; hif.id_use_rs2 = 1; hif.ex_redirect = 1;
    cycle();
    clr();
    cycle();
    hif.ex_redirect = 1;
    cycle();
    clr();
    // Halt, redirect mid-drain, halted, reset
    hif.id_halt = 1;
    cycle();
    cycle();
    hif.ex_redirect = 1;
    cycle();
    hif.ex_redirect = 0;
    run(7);
    rst = 0;
    cycle();
    clr();
    run(3);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      hif.id_rs1 = 5'($urandom_range(0, 7));
      hif.id_rs2 = 5'($urandom_range(0, 7));
      hif.id_use_rs1 = 1'($urandom);
      hif.id_use_rs2 = 1'($urandom);
      hif.id_halt = ($urandom_range(0, 29) == 0);
      hif.ex_rs1 = 5'($urandom_range(0, 7));
      hif.ex_rs2 = 5'($urandom_range(0, 7));
      hif.ex_rd = 5'($urandom_range(0, 7));
      hif.ex_RegWrite = 1'($urandom);
      hif.ex_MemRead = ($urandom_range(0, 2) == 0);
      hif.ex_redirect = ($urandom_range(0, 5) == 0);
      hif.mem_rd = 5'($urandom_range(0, 7));
      hif.mem_RegWrite = 1'($urandom);
      hif.wb_rd = 5'($urandom_range(0, 7));
      hif.wb_RegWrite = 1'($urandom);
      if (halt_t >= 0 && cyc - halt_t > D)
        rst = ($urandom_range(0, 7) != 0);
      else
        rst = ($urandom_range(0, 79) != 0);
      cycle();
    end
    clr();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_queue left=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
